// File: rtl/seg_addr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg_addr_pkg                                                               |
// | Shared types and helpers for the segmented address sequencer family.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package seg_addr_pkg;

  // Wide enough for any length/address arithmetic done through min3.
  localparam int unsigned WIDE_W = 128;
  typedef logic [WIDE_W-1:0] wide_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_EMIT = 3'd2,
    ST_ADD  = 3'd3,
    ST_SUB  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  function automatic int unsigned calc_nseg(input int unsigned addr_w,
                                            input int unsigned chunk_w);
    return (addr_w + chunk_w - 1) / chunk_w;
  endfunction

  function automatic wide_t min3(input wide_t a, input wide_t b, input wide_t c);
    wide_t m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_carry_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg_carry_adder                                                            |
// | Accumulating adder that adds one CHUNK_W slice per cycle, LSB first.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module seg_carry_adder
  import seg_addr_pkg::*;
#(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned CHUNK_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] addend_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             done_o
);

  localparam int unsigned NSEG  = calc_nseg(WIDTH, CHUNK_W);
  localparam int unsigned PAD_W = NSEG * CHUNK_W;
  localparam int unsigned IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSEG - 1);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] addend_q, addend_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             run_q, run_d;

  logic [PAD_W-1:0] acc_pad, addend_pad, next_pad;
  logic [CHUNK_W:0] seg_sum;

  always_comb begin
    // Padding lets the narrower top segment share the slice logic; bits above
    // WIDTH (and the final carry) are dropped, giving modulo-2^WIDTH wrap.
    acc_pad    = PAD_W'(acc_q);
    addend_pad = PAD_W'(addend_q);
    seg_sum    = {1'b0, acc_pad[idx_q*CHUNK_W +: CHUNK_W]}
               + {1'b0, addend_pad[idx_q*CHUNK_W +: CHUNK_W]}
               + {{CHUNK_W{1'b0}}, carry_q};
    next_pad   = acc_pad;
    next_pad[idx_q*CHUNK_W +: CHUNK_W] = seg_sum[CHUNK_W-1:0];

    acc_d    = acc_q;
    addend_d = addend_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    run_d    = run_q;
    done_o   = run_q && (idx_q == LAST_IDX);

    if (load_i) begin
      acc_d   = load_val_i;
      run_d   = 1'b0;
      carry_d = 1'b0;
      idx_d   = '0;
    end else if (start_i) begin
      addend_d = addend_i;
      run_d    = 1'b1;
      carry_d  = 1'b0;
      idx_d    = '0;
    end else if (run_q) begin
      acc_d   = next_pad[WIDTH-1:0];
      carry_d = seg_sum[CHUNK_W];
      idx_d   = idx_q + 1'b1;
      if (done_o) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      addend_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      addend_q <= addend_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      run_q    <= run_d;
    end
  end

  assign sum_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/segmented_address_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | segmented_address_sequencer                                                |
// | Splits a (start, length) transfer into burst descriptors over valid/ready.|
// | Optional boundary split: define SEG_ADDR_BOUNDARY_SPLIT_EN.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module segmented_address_sequencer
  import seg_addr_pkg::*;
#(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned LEN_W     = 36,
  parameter int unsigned CHUNK_W   = 16,
  parameter int unsigned MAX_BURST = 4096,
  parameter int unsigned BOUNDARY  = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_i,
  input  logic [ADDR_W-1:0] init_addr_i,
  input  logic [LEN_W-1:0]  init_len_i,
  output logic              desc_valid_o,
  input  logic              desc_ready_i,
  output logic [ADDR_W-1:0] desc_addr_o,
  output logic [LEN_W-1:0]  desc_size_o,
  output logic              desc_last_o,
  output logic [LEN_W-1:0]  remaining_len_o,
  output logic              busy_o,
  output logic              complete_o
);

  if ((MAX_BURST == 0) || (CHUNK_W == 0) || (BOUNDARY == 0) ||
      ((BOUNDARY & (BOUNDARY - 1)) != 0)) begin : g_param_check
    $error("segmented_address_sequencer: illegal MAX_BURST/CHUNK_W/BOUNDARY");
  end

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [LEN_W-1:0]  size_q, size_d;
  logic              last_q, last_d;

  logic              add_load, add_start, add_done;
  logic [ADDR_W-1:0] addr;
  wide_t             room;
  logic [LEN_W-1:0]  burst;

  seg_carry_adder #(
    .WIDTH   (ADDR_W),
    .CHUNK_W (CHUNK_W)
  ) u_adder (
    .clk        (clk),
    .rst        (rst),
    .load_i     (add_load),
    .load_val_i (init_addr_i),
    .start_i    (add_start),
    .addend_i   (ADDR_W'(size_q)),
    .sum_o      (addr),
    .done_o     (add_done)
  );

`ifdef SEG_ADDR_BOUNDARY_SPLIT_EN
  assign room = wide_t'(BOUNDARY) - (wide_t'(addr) & wide_t'(BOUNDARY - 1));
`else
  assign room = wide_t'(MAX_BURST);
`endif

  assign burst = LEN_W'(min3(wide_t'(remaining_q), wide_t'(MAX_BURST), room));

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    size_d      = size_q;
    last_d      = last_q;
    add_start   = 1'b0;
    add_load    = 1'b0;

    case (state_q)
      ST_CALC: begin
        size_d  = burst;
        last_d  = (burst == remaining_q);
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (desc_ready_i) begin
          add_start = 1'b1;
          state_d   = ST_ADD;
        end
      end
      ST_ADD: begin
        if (add_done) state_d = ST_SUB;
      end
      ST_SUB: begin
        remaining_d = remaining_q - size_q;
        state_d     = (remaining_q == size_q) ? ST_DONE : ST_CALC;
      end
      default: ;
    endcase

    // A new command abandons whatever is in flight, including a running add.
    if (init_i) begin
      add_load    = 1'b1;
      add_start   = 1'b0;
      remaining_d = init_len_i;
      state_d     = (init_len_i == '0) ? ST_DONE : ST_CALC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      size_q      <= '0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      size_q      <= size_d;
      last_q      <= last_d;
    end
  end

  assign desc_valid_o    = (state_q == ST_EMIT);
  assign desc_addr_o     = addr;
  assign desc_size_o     = size_q;
  assign desc_last_o     = last_q;
  assign remaining_len_o = remaining_q;
  assign busy_o          = (state_q == ST_CALC) || (state_q == ST_EMIT) ||
                           (state_q == ST_ADD)  || (state_q == ST_SUB);
  assign complete_o      = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_segmented_address_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_segmented_address_sequencer                                             |
// | Directed and randomized transfers checked against a descriptor list model.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_segmented_address_sequencer;

  localparam int ADDR_W    = 64;
  localparam int LEN_W     = 36;
  localparam int CHUNK_W   = 16;
  localparam int NSEG      = 4;
  localparam int MAX_BURST = 4096;
  localparam int BOUNDARY  = 4096;

  logic              clk = 1'b0;
  logic              rst;
  logic              init;
  logic [ADDR_W-1:0] init_addr;
  logic [LEN_W-1:0]  init_len;
  logic              desc_valid;
  logic              desc_ready;
  logic [ADDR_W-1:0] desc_addr;
  logic [LEN_W-1:0]  desc_size;
  logic              desc_last;
  logic [LEN_W-1:0]  remaining_len;
  logic              busy;
  logic              complete;

  always #5 clk = ~clk;

  segmented_address_sequencer #(
    .ADDR_W    (ADDR_W),
    .LEN_W     (LEN_W),
    .CHUNK_W   (CHUNK_W),
    .MAX_BURST (MAX_BURST),
    .BOUNDARY  (BOUNDARY)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .init_i          (init),
    .init_addr_i     (init_addr),
    .init_len_i      (init_len),
    .desc_valid_o    (desc_valid),
    .desc_ready_i    (desc_ready),
    .desc_addr_o     (desc_addr),
    .desc_size_o     (desc_size),
    .desc_last_o     (desc_last),
    .remaining_len_o (remaining_len),
    .busy_o          (busy),
    .complete_o      (complete)
  );

  typedef struct {
    logic [63:0] addr;
    logic [35:0] size;
    bit          last;
  } desc_t;

  desc_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: the list of bursts a transfer must be carved into.
  task automatic build_model(input logic [63:0] a, input logic [35:0] l);
    logic [63:0] cur;
    logic [35:0] rem;
    logic [35:0] sz;
    logic [63:0] lim;
    cur = a;
    rem = l;
    exp_q.delete();
    while (rem != 0) begin
      sz = (rem < 36'(MAX_BURST)) ? rem : 36'(MAX_BURST);
`ifdef SEG_ADDR_BOUNDARY_SPLIT_EN
      lim = 64'(BOUNDARY) - (cur % 64'(BOUNDARY));
`else
      lim = 64'(MAX_BURST);
`endif
      if (lim < 64'(sz)) sz = 36'(lim);
      exp_q.push_back('{cur, sz, (sz == rem)});
      cur = cur + 64'(sz);
      rem = rem - sz;
    end
  endtask

  task automatic start(input logic [63:0] a, input logic [35:0] l);
    init      = 1'b1;
    init_addr = a;
    init_len  = l;
    @(negedge clk);
    init      = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int c = 0;
    while (!desc_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
    check(tag, 64'(desc_valid), 64'd1);
  endtask

  // Entered on the negedge right after init was dropped.
  task automatic collect(input logic [63:0] a, input logic [35:0] l,
                         input int pct, input int hold);
    int          cyc, idx, since, hold_left;
    bit          waiting_gap, prev_stall, seen_first;
    logic [63:0] h_addr;
    logic [35:0] h_size;
    logic        h_last;
    logic [35:0] rem_exp;

    build_model(a, l);
    cyc = 0; idx = 0; since = 0; hold_left = hold;
    waiting_gap = 0; prev_stall = 0; seen_first = 0;
    rem_exp = l;
    h_addr = '0; h_size = '0; h_last = 1'b0;

    if (l == 0) begin
      check("zero_len_valid", 64'(desc_valid), 64'd0);
      check("zero_len_complete", 64'(complete), 64'd1);
      check("zero_len_busy", 64'(busy), 64'd0);
      return;
    end

    check("complete_cleared", 64'(complete), 64'd0);
    check("busy_after_init", 64'(busy), 64'd1);

    while (idx < exp_q.size() && cyc < 4000) begin
      desc_ready = 1'b0;
      if (prev_stall) begin
        check("valid_held", 64'(desc_valid), 64'd1);
        if (desc_valid) begin
          check("hold_addr", desc_addr, h_addr);
          check("hold_size", 64'(desc_size), 64'(h_size));
          check("hold_last", 64'(desc_last), 64'(h_last));
        end
        prev_stall = 0;
      end
      if (desc_valid) begin
        if (!seen_first) begin
          check("first_latency", 64'(cyc), 64'd1);
          seen_first = 1;
        end
        if (waiting_gap) begin
          // Handshake edge is half a cycle after this sampling point, so
          // reassertion at edge k+NSEG+2 is first visible NSEG+3 negedges on.
          check("reassert_gap", 64'(since), 64'(NSEG + 3));
          waiting_gap = 0;
        end
        if (hold_left > 0) hold_left--;
        else desc_ready = (int'($urandom_range(99)) < pct);
        if (desc_ready) begin
          check("desc_addr", desc_addr, exp_q[idx].addr);
          check("desc_size", 64'(desc_size), 64'(exp_q[idx].size));
          check("desc_last", 64'(desc_last), 64'(exp_q[idx].last));
          check("remaining_len", 64'(remaining_len), 64'(rem_exp));
          rem_exp     = rem_exp - exp_q[idx].size;
          idx++;
          waiting_gap = 1;
          since       = 0;
        end else begin
          prev_stall = 1;
          h_addr = desc_addr; h_size = desc_size; h_last = desc_last;
        end
      end
      @(negedge clk);
      cyc++;
      since++;
    end
    desc_ready = 1'b0;
    check("all_desc_issued", 64'(idx), 64'(exp_q.size()));

    cyc = 0;
    while (!complete && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("complete", 64'(complete), 64'd1);
    check("complete_latency", 64'(cyc), 64'(NSEG + 1));
    check("remaining_zero", 64'(remaining_len), 64'd0);
    check("busy_done", 64'(busy), 64'd0);
    check("valid_done", 64'(desc_valid), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ra;
    logic [35:0] rl;
    int          vcount;

    rst = 1'b1; init = 1'b0; init_addr = '0; init_len = '0; desc_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(desc_valid), 64'd0);
    check("rst_addr", desc_addr, 64'd0);
    check("rst_size", 64'(desc_size), 64'd0);
    check("rst_last", 64'(desc_last), 64'd0);
    check("rst_remaining", 64'(remaining_len), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_complete", 64'(complete), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic split, carry chain, wrap with a 10-cycle stall, boundary case.
    start(64'h1000, 36'd10000);
    collect(64'h1000, 36'd10000, 100, 0);
    start(64'h0000_FFFF_FFFF_F000, 36'd8192);
    collect(64'h0000_FFFF_FFFF_F000, 36'd8192, 100, 0);
    start(64'hFFFF_FFFF_FFFF_F000, 36'd8192);
    collect(64'hFFFF_FFFF_FFFF_F000, 36'd8192, 100, 10);
    start(64'h0F00, 36'd512);
    collect(64'h0F00, 36'd512, 70, 0);

    start(64'h1234, 36'd0);
    collect(64'h1234, 36'd0, 100, 0);

    // Restart while the adder is mid-chain.
    start(64'h0004_0000, 36'd20000);
    wait_valid("restart_first_valid");
    desc_ready = 1'b1;
    @(negedge clk);
    desc_ready = 1'b0;
    start(64'h00AB_CDEF_0123_4567, 36'd9000);
    collect(64'h00AB_CDEF_0123_4567, 36'd9000, 100, 0);

    for (int i = 0; i < 8; i++) begin
      ra = {$urandom(), $urandom()};
      if ($urandom_range(3) == 0) ra[63:16] = '1;
      rl = 36'($urandom_range(1, 20000));
      start(ra, rl);
      collect(ra, rl, int'($urandom_range(30, 100)), int'($urandom_range(0, 3)));
    end

    // Reset while a descriptor is being offered.
    start(64'h5000, 36'd9000);
    wait_valid("rst_mid_valid");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst2_valid", 64'(desc_valid), 64'd0);
    check("rst2_addr", desc_addr, 64'd0);
    check("rst2_size", 64'(desc_size), 64'd0);
    check("rst2_remaining", 64'(remaining_len), 64'd0);
    check("rst2_busy", 64'(busy), 64'd0);
    check("rst2_complete", 64'(complete), 64'd0);
    vcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (desc_valid || busy) vcount++;
    end
    check("rst2_idle_quiet", 64'(vcount), 64'd0);

    start(64'h2_0000_0800, 36'd5000);
    collect(64'h2_0000_0800, 36'd5000, 60, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
